// File: rtl/ativiade5_pkg.sv
// rtl/ativiade5_pkg.sv - register map constants for the output PIO
package ativiade5_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_OUTSET   = 2'd1;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd2;
    localparam logic [1:0] ADDR_PULSE    = 2'd3;

    localparam int BUSY_BIT = 31;

endpackage

// File: rtl/ativiade5_pulse_timer.sv
// rtl/ativiade5_pulse_timer.sv - one-shot pulse mask with down-counter
module ativiade5_pulse_timer #(
    parameter int DATA_WIDTH   = 8,
    parameter int PULSE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_mask,
    output logic [DATA_WIDTH-1:0] mask,
    output logic                  busy
);

    localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    logic [DATA_WIDTH-1:0] r_mask;
    logic [CNT_W-1:0]      r_cnt;

    // Counter holds cycles left after the current one; mask drops on the edge after it hits zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_mask <= load_mask;
            r_cnt  <= (load_mask != '0) ? CNT_LOAD : '0;
        end else if (r_mask != '0) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_mask <= '0;
            end
        end
    end

    assign mask = r_mask;
    assign busy = (r_mask != '0);

endmodule

// File: rtl/ativiade5_pio_out.sv
// rtl/ativiade5_pio_out.sv - Avalon-MM output PIO with set/clear and timed pulse
module ativiade5_pio_out
    import ativiade5_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PULSE_CYCLES = 50000,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wd;
    logic                  w_unused_wd;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_busy;
    logic [31:0]           w_rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic [31:0]           r_readdata;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[DATA_WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    ativiade5_pulse_timer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_pulse_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_wr && (address == ADDR_PULSE)),
        .load_mask(w_wd),
        .mask     (w_mask),
        .busy     (w_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= RESET_VALUE;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:     r_data <= w_wd;
                ADDR_OUTSET:   r_data <= r_data | w_wd;
                ADDR_OUTCLEAR: r_data <= r_data & ~w_wd;
                default:       r_data <= r_data;
            endcase
        end
    end

    // Readback reflects register contents, not out_port.
    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA: w_rd[DATA_WIDTH-1:0] = r_data;
            ADDR_PULSE: begin
                w_rd[DATA_WIDTH-1:0] = w_mask;
                w_rd[BUSY_BIT]       = w_rd[BUSY_BIT] | w_busy;
            end
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data ^ w_mask;

endmodule
